// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed on-chip SRAM; read and write channels run as independent FSMs.
// Optional build macro AXI_SRAM_PERF_EN adds internal 64-bit performance counters (no port or timing change).
module axi4_lite_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE_X      = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT_X     = BASE_X + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  LAT_INIT    = 4'(RD_LATENCY - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;

  // Window check done in 33 bits so a window touching 4 GiB cannot wrap.
  function automatic logic addr_hit(input logic [31:0] a);
    logic [32:0] ax;
    ax = {1'b0, a};
    return (ax >= BASE_X) && (ax < LIMIT_X);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  wstate_e     wstate_q, wstate_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  rstate_e     rstate_q, rstate_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [31:0] raddr_q, raddr_d;

  logic             aw_hs, w_hs, ar_hs;
  logic             whit, rhit, mem_we;
  logic [32:0]      woff, roff;
  logic [IDX_W-1:0] widx, ridx;
  logic             unused_addr_bits;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;
  assign ar_hs = arvalid & arready_q;

  assign whit = addr_hit(waddr_q);
  assign rhit = addr_hit(raddr_q);
  assign woff = {1'b0, waddr_q} - BASE_X;
  assign roff = {1'b0, raddr_q} - BASE_X;
  assign widx = woff[IDX_W+1:2];
  assign ridx = roff[IDX_W+1:2];

  // Byte lane and out-of-window offset bits carry no meaning once decoded.
  assign unused_addr_bits = ^{woff[32:IDX_W+2], woff[1:0], roff[32:IDX_W+2], roff[1:0]};

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_we    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          waddr_d  = awaddr;
          aw_got_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
          w_got_d = 1'b1;
        end
        awready_d = ~aw_got_d;
        wready_d  = ~w_got_d;
        if (aw_got_d && w_got_d) begin
          wstate_d = W_EXEC;
        end
      end
      W_EXEC: begin
        mem_we   = whit;
        bvalid_d = 1'b1;
        bresp_d  = whit ? RESP_OKAY : RESP_DECERR;
        aw_got_d = 1'b0;
        w_got_d  = 1'b0;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Array is read combinationally in the sample cycle, so a same-cycle commit is not yet visible.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          raddr_d   = araddr;
          arready_d = 1'b0;
          rcnt_d    = LAT_INIT;
          rstate_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 4'd0) begin
          rvalid_d = 1'b1;
          rdata_d  = rhit ? mem[ridx] : 32'd0;
          rresp_d  = rhit ? RESP_OKAY : RESP_DECERR;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          rdata_d   = 32'd0;
          rresp_d   = RESP_OKAY;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'd0;
      rcnt_q    <= 4'd0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Captured request payload is only consumed under FSM control, so it needs no reset.
  always_ff @(posedge clk) begin
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    raddr_q <= raddr_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

`ifdef AXI_SRAM_PERF_EN
  logic [63:0] perf_rd_cnt;
  logic [63:0] perf_wr_cnt;
  logic [63:0] perf_decerr_cnt;
  logic [63:0] perf_rstall_cycles;
  logic [63:0] perf_bstall_cycles;
  logic        r_done, b_done, r_dec, b_dec;

  assign r_done = rvalid_q & rready;
  assign b_done = bvalid_q & bready;
  assign r_dec  = r_done & (rresp_q == RESP_DECERR);
  assign b_dec  = b_done & (bresp_q == RESP_DECERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt        <= 64'd0;
      perf_wr_cnt        <= 64'd0;
      perf_decerr_cnt    <= 64'd0;
      perf_rstall_cycles <= 64'd0;
      perf_bstall_cycles <= 64'd0;
    end else begin
      perf_rd_cnt        <= perf_rd_cnt + 64'(r_done);
      perf_wr_cnt        <= perf_wr_cnt + 64'(b_done);
      perf_decerr_cnt    <= perf_decerr_cnt + 64'(r_dec) + 64'(b_dec);
      perf_rstall_cycles <= perf_rstall_cycles + 64'(rvalid_q & ~rready);
      perf_bstall_cycles <= perf_bstall_cycles + 64'(bvalid_q & ~bready);
    end
  end
`else
  // Counters are compiled out; the datapath above is unaffected.
`endif

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Directed bench for axi4_lite_sram_slave: a byte-lane memory model plus a per-cycle response checker.
module tb_axi4_lite_sram_slave;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 1024;
  localparam int          RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [int unsigned];
  logic        r_expect = 1'b0;
  logic        b_expect = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic [1:0]  exp_rresp = 2'd0;
  logic [1:0]  exp_bresp = 2'd0;

  always #5 clk = ~clk;

  axi4_lite_sram_slave #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready)
  );

  function automatic bit model_hit(input logic [31:0] a);
    longint unsigned lo, hi, x;
    lo = 64'(BASE);
    hi = lo + 64'(4 * DEPTH);
    x  = 64'(a);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic int unsigned model_idx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!model_hit(a)) return 32'd0;
    if (!ref_mem.exists(model_idx(a))) return 32'd0;
    return ref_mem[model_idx(a)];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (model_hit(a)) begin
      w = ref_mem.exists(model_idx(a)) ? ref_mem[model_idx(a)] : 32'd0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[model_idx(a)] = w;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=no handshake required=handshake within 20 cycles at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle checker: any response on the bus must be expected and carry the model's value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        check("rvalid_expected", 32'(r_expect), 32'd1);
        if (r_expect) begin
          check("rdata", rdata, exp_rdata);
          check("rresp", 32'(rresp), 32'(exp_rresp));
        end
      end
      if (bvalid) begin
        check("bvalid_expected", 32'(b_expect), 32'd1);
        if (b_expect) check("bresp", 32'(bresp), 32'(exp_bresp));
      end
    end
  end

  task automatic read_word(input logic [31:0] a, input int rr_dly,
                           output logic [31:0] got, output logic [1:0] gresp);
    int n;
    exp_rdata = model_read(a);
    exp_rresp = model_hit(a) ? 2'b00 : 2'b11;
    r_expect  = 1'b1;
    araddr    = a;
    arvalid   = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    if (!arready) timeout("ar_handshake");
    tick();
    arvalid = 1'b0;
    check("arready_drop", 32'(arready), 32'd0);
    check("rvalid_before_lat", 32'(rvalid), 32'd0);
    for (int k = 1; k <= RD_LAT; k++) begin
      tick();
      if (k < RD_LAT) check("rvalid_before_lat", 32'(rvalid), 32'd0);
      else            check("rvalid_at_lat", 32'(rvalid), 32'd1);
    end
    got   = rdata;
    gresp = rresp;
    for (int k = 0; k < rr_dly; k++) begin
      tick();
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_stable", rdata, got);
      check("arready_low_in_resp", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    tick();
    rready   = 1'b0;
    r_expect = 1'b0;
    check("rvalid_clear", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] gresp);
    exp_bresp = model_hit(a) ? 2'b00 : 2'b11;
    b_expect  = 1'b1;
    fork
      begin
        int n;
        repeat (aw_dly) tick();
        awaddr  = a;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
          tick();
          n++;
        end
        if (!awready) timeout("aw_handshake");
        tick();
        awvalid = 1'b0;
        check("awready_drop", 32'(awready), 32'd0);
      end
      begin
        int n;
        repeat (w_dly) tick();
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin
          tick();
          n++;
        end
        if (!wready) timeout("w_handshake");
        tick();
        wvalid = 1'b0;
        check("wready_drop", 32'(wready), 32'd0);
      end
    join
    check("bvalid_early", 32'(bvalid), 32'd0);
    tick();
    check("bvalid_at_2", 32'(bvalid), 32'd1);
    model_write(a, d, s);
    gresp = bresp;
    for (int k = 0; k < b_dly; k++) begin
      tick();
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("bresp_stable", 32'(bresp), 32'(gresp));
    end
    bready = 1'b1;
    tick();
    bready   = 1'b0;
    b_expect = 1'b0;
    check("bvalid_clear", 32'(bvalid), 32'd0);
    check("awready_back", 32'(awready), 32'd1);
    check("wready_back", 32'(wready), 32'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_awready"}, 32'(awready), 32'd0);
    check({nm, "_wready"},  32'(wready),  32'd0);
    check({nm, "_arready"}, 32'(arready), 32'd0);
    check({nm, "_bvalid"},  32'(bvalid),  32'd0);
    check({nm, "_bresp"},   32'(bresp),   32'd0);
    check({nm, "_rvalid"},  32'(rvalid),  32'd0);
    check({nm, "_rdata"},   rdata,        32'd0);
    check({nm, "_rresp"},   32'(rresp),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] g;
    logic [1:0]  gr, br;
    rst_n   = 1'b0;
    awaddr  = 32'd0; awvalid = 1'b0;
    wdata   = 32'd0; wstrb   = 4'd0; wvalid = 1'b0;
    bready  = 1'b0;
    araddr  = 32'd0; arvalid = 1'b0;
    rready  = 1'b0;

    repeat (2) tick();
    check_all_zero("por");
    rst_n = 1'b1;
    check("por_release_arready", 32'(arready), 32'd0);
    tick();
    check("por_awready", 32'(awready), 32'd1);
    check("por_wready",  32'(wready),  32'd1);
    check("por_arready", 32'(arready), 32'd1);

    // Reset while a read waits for its latency: the read must vanish.
    araddr  = BASE;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_all_zero("midrd_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    check("midrd_release_awready", 32'(awready), 32'd0);
    tick();
    check("midrd_awready", 32'(awready), 32'd1);
    check("midrd_wready",  32'(wready),  32'd1);
    check("midrd_arready", 32'(arready), 32'd1);
    for (int k = 0; k < RD_LAT + 3; k++) begin
      check("midrd_no_rvalid", 32'(rvalid), 32'd0);
      tick();
    end

    // Preload first and last words of the window.
    write_word(BASE,                32'hA5A5_0001, 4'hF, 0, 0, 0, br);
    check("pre0_bresp", 32'(br), 32'd0);
    write_word(BASE + 32'h0000_0FFC, 32'h0F0F_F0F0, 4'hF, 0, 0, 0, br);
    check("prelast_bresp", 32'(br), 32'd0);

    // Full write then single-lane merge.
    write_word(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br);
    check("t2_bresp_a", 32'(br), 32'd0);
    write_word(BASE + 32'h10, 32'h0000_5500, 4'b0010, 0, 0, 0, br);
    check("t2_bresp_b", 32'(br), 32'd0);
    read_word(BASE + 32'h10, 0, g, gr);
    check("t2_rdata", g, 32'hDEAD_55EF);
    check("t2_rresp", 32'(gr), 32'd0);

    write_word(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 1, 0, 0, br);
    write_word(BASE + 32'h10, 32'h1122_3344, 4'b1001, 0, 1, 0, br);
    read_word(BASE + 32'h13, 1, g, gr);
    check("strb_rdata", g, 32'h11AD_5544);

    // W leads AW by three cycles, then a slow bready.
    write_word(BASE + 32'h20, 32'h1234_5678, 4'hF, 3, 0, 4, br);
    check("t3_bresp", 32'(br), 32'd0);

    // Out-of-window accesses on both sides of the window.
    read_word(32'h7FFF_FFFC, 0, g, gr);
    check("t4_rdata", g, 32'd0);
    check("t4_rresp", 32'(gr), 32'd3);
    write_word(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, 0, 2, br);
    check("t4_bresp", 32'(br), 32'd3);
    read_word(BASE, 0, g, gr);
    check("t4_word0_intact", g, 32'hA5A5_0001);
    read_word(BASE + 32'h0000_0FFC, 0, g, gr);
    check("t4_lastword", g, 32'h0F0F_F0F0);
    check("t4_lastword_rresp", 32'(gr), 32'd0);

    // Slow rready.
    read_word(BASE + 32'h20, 5, g, gr);
    check("t5_rdata", g, 32'h1234_5678);

    // Read sample lands in the W_EXEC cycle of a write to the same word.
    write_word(BASE + 32'h40, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, br);
    fork
      write_word(BASE + 32'h40, 32'hBBBB_BBBB, 4'hF, 2, 2, 0, br);
      read_word(BASE + 32'h40, 0, g, gr);
    join
    check("t6_old_data", g, 32'hAAAA_AAAA);
    read_word(BASE + 32'h40, 0, g, gr);
    check("t6_new_data", g, 32'hBBBB_BBBB);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
